// File: rtl/memory_port_requester_if.sv
// Client request/response and memory-port signals of one memory_port_requester.
// master: the requester; slave: the client plus the memory port it talks to.
interface memory_port_requester_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned TAG_W  = 2
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              req_wen;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_wen;
    logic [TAG_W-1:0]  port_req_tag_in;
    logic [ADDR_W-1:0] port_addr;
    logic [DATA_W-1:0] port_data_in;
    logic              port_wen;
    logic              port_valid;
    logic              freeze_inputs;
    logic [TAG_W-1:0]  port_req_tag_out;
    logic [DATA_W-1:0] port_data_out;
    logic              port_valid_out;
    logic              protocol_error;

    modport master (
        input  req_valid, req_addr, req_data, req_wen, rsp_ready, freeze_inputs,
               port_req_tag_out, port_data_out, port_valid_out,
        output req_ready, rsp_valid, rsp_data, rsp_wen, port_req_tag_in, port_addr,
               port_data_in, port_wen, port_valid, protocol_error
    );

    modport slave (
        output req_valid, req_addr, req_data, req_wen, rsp_ready, freeze_inputs,
               port_req_tag_out, port_data_out, port_valid_out,
        input  req_ready, rsp_valid, rsp_data, rsp_wen, port_req_tag_in, port_addr,
               port_data_in, port_wen, port_valid, protocol_error
    );
endinterface

// File: rtl/memory_port_requester.sv
// Tagged memory-port initiator: issues client requests with rotating tags and
// returns out-of-order memory responses to the client in issue order.
module memory_port_requester #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned TAG_W  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    memory_port_requester_if.master bus
);
    localparam int unsigned     Depth    = 2 ** TAG_W;
    localparam logic [TAG_W:0]  DepthCnt = (TAG_W + 1)'(Depth);

    logic [TAG_W-1:0]  issue_ptr_q, issue_ptr_d;
    logic [TAG_W-1:0]  ret_ptr_q, ret_ptr_d;
    logic [TAG_W:0]    count_q, count_d;
    logic [Depth-1:0]  alloc_q, alloc_d;
    logic [Depth-1:0]  done_q, done_d;
    logic [Depth-1:0]  wen_q, wen_d;
    logic [DATA_W-1:0] data_q [Depth];
    logic [DATA_W-1:0] data_d [Depth];

    logic              port_valid_q, port_valid_d;
    logic [TAG_W-1:0]  port_tag_q, port_tag_d;
    logic [ADDR_W-1:0] port_addr_q, port_addr_d;
    logic [DATA_W-1:0] port_data_q, port_data_d;
    logic              port_wen_q, port_wen_d;
    logic              err_q, err_d;

    logic              req_ready;
    logic              req_fire;
    logic              rsp_fire;
    logic              rsp_hit;
    logic [TAG_W-1:0]  rsp_tag;

    // A frozen, still-pending port request must not be overwritten.
    assign req_ready = (count_q < DepthCnt) && (!port_valid_q || !bus.freeze_inputs);
    assign req_fire  = bus.req_valid && req_ready;
    assign rsp_fire  = done_q[ret_ptr_q] && bus.rsp_ready;
    assign rsp_tag   = bus.port_req_tag_out;
    assign rsp_hit   = bus.port_valid_out && alloc_q[rsp_tag] && !done_q[rsp_tag];

    always_comb begin
        issue_ptr_d  = issue_ptr_q;
        ret_ptr_d    = ret_ptr_q;
        alloc_d      = alloc_q;
        done_d       = done_q;
        wen_d        = wen_q;
        data_d       = data_q;
        port_valid_d = port_valid_q;
        port_tag_d   = port_tag_q;
        port_addr_d  = port_addr_q;
        port_data_d  = port_data_q;
        port_wen_d   = port_wen_q;
        err_d        = err_q || (bus.port_valid_out && !rsp_hit);
        count_d      = count_q + (TAG_W + 1)'(req_fire) - (TAG_W + 1)'(rsp_fire);

        if (rsp_fire) begin
            alloc_d[ret_ptr_q] = 1'b0;
            done_d[ret_ptr_q]  = 1'b0;
            ret_ptr_d          = ret_ptr_q + TAG_W'(1);
        end

        if (req_fire) begin
            alloc_d[issue_ptr_q] = 1'b1;
            done_d[issue_ptr_q]  = 1'b0;
            wen_d[issue_ptr_q]   = bus.req_wen;
            issue_ptr_d          = issue_ptr_q + TAG_W'(1);
            port_valid_d         = 1'b1;
            port_tag_d           = issue_ptr_q;
            port_addr_d          = bus.req_addr;
            port_data_d          = bus.req_data;
            port_wen_d           = bus.req_wen;
        end else if (port_valid_q && !bus.freeze_inputs) begin
            port_valid_d = 1'b0;
        end

        // Responses never target the entry retiring this cycle (it is already done).
        if (rsp_hit) begin
            data_d[rsp_tag] = bus.port_data_out;
            done_d[rsp_tag] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            issue_ptr_q  <= '0;
            ret_ptr_q    <= '0;
            count_q      <= '0;
            alloc_q      <= '0;
            done_q       <= '0;
            wen_q        <= '0;
            data_q       <= '{default: '0};
            port_valid_q <= 1'b0;
            port_tag_q   <= '0;
            port_addr_q  <= '0;
            port_data_q  <= '0;
            port_wen_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            issue_ptr_q  <= issue_ptr_d;
            ret_ptr_q    <= ret_ptr_d;
            count_q      <= count_d;
            alloc_q      <= alloc_d;
            done_q       <= done_d;
            wen_q        <= wen_d;
            data_q       <= data_d;
            port_valid_q <= port_valid_d;
            port_tag_q   <= port_tag_d;
            port_addr_q  <= port_addr_d;
            port_data_q  <= port_data_d;
            port_wen_q   <= port_wen_d;
            err_q        <= err_d;
        end
    end

    assign bus.req_ready       = req_ready;
    assign bus.rsp_valid       = done_q[ret_ptr_q];
    assign bus.rsp_data        = data_q[ret_ptr_q];
    assign bus.rsp_wen         = wen_q[ret_ptr_q];
    assign bus.port_valid      = port_valid_q;
    assign bus.port_req_tag_in = port_tag_q;
    assign bus.port_addr       = port_addr_q;
    assign bus.port_data_in    = port_data_q;
    assign bus.port_wen        = port_wen_q;
    assign bus.protocol_error  = err_q;
endmodule

// File: tb/tb_memory_port_requester.sv
// Directed per-cycle vector table for memory_port_requester, followed by a few
// hand-written request/response round trips across the tag wrap.
module tb_memory_port_requester;
    typedef struct packed {
        logic        rst;
        logic        rv;
        logic [11:0] ra;
        logic [15:0] rd;
        logic        rw;
        logic        rr;
        logic        frz;
        logic        pvo;
        logic [1:0]  pt;
        logic [15:0] pd;
    } in_t;

    typedef struct packed {
        logic        rdy;
        logic        rv;
        logic [15:0] rdata;
        logic        rwen;
        logic        pv;
        logic [1:0]  pt;
        logic [11:0] pa;
        logic [15:0] pd;
        logic        pw;
        logic        err;
    } exp_t;

    typedef struct {
        string name;
        bit    full;
        in_t   i;
        exp_t  e;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t tbl[$];

    memory_port_requester_if #(.ADDR_W(12), .DATA_W(16), .TAG_W(2)) bus ();

    memory_port_requester #(.ADDR_W(12), .DATA_W(16), .TAG_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic in_t vi(int rst, int rv, int ra, int rd, int rw, int rr, int frz,
                               int pvo, int pt, int pd);
        in_t r;
        r.rst = rst[0]; r.rv = rv[0]; r.ra = ra[11:0]; r.rd = rd[15:0]; r.rw = rw[0];
        r.rr = rr[0]; r.frz = frz[0]; r.pvo = pvo[0]; r.pt = pt[1:0]; r.pd = pd[15:0];
        return r;
    endfunction

    function automatic exp_t ve(int rdy, int rv, int rdata, int rwen, int pv, int pt, int pa,
                                int pd, int pw, int err);
        exp_t r;
        r.rdy = rdy[0]; r.rv = rv[0]; r.rdata = rdata[15:0]; r.rwen = rwen[0]; r.pv = pv[0];
        r.pt = pt[1:0]; r.pa = pa[11:0]; r.pd = pd[15:0]; r.pw = pw[0]; r.err = err[0];
        return r;
    endfunction

    task automatic add(input string nm, input bit full, input in_t i, input exp_t e);
        vec_t v;
        v.name = nm; v.full = full; v.i = i; v.e = e;
        tbl.push_back(v);
    endtask

    task automatic drive(input in_t i);
        reset                = i.rst;
        bus.req_valid        = i.rv;
        bus.req_addr         = i.ra;
        bus.req_data         = i.rd;
        bus.req_wen          = i.rw;
        bus.rsp_ready        = i.rr;
        bus.freeze_inputs    = i.frz;
        bus.port_valid_out   = i.pvo;
        bus.port_req_tag_out = i.pt;
        bus.port_data_out    = i.pd;
    endtask

    function automatic exp_t sample();
        exp_t a;
        a.rdy = bus.req_ready; a.rv = bus.rsp_valid; a.rdata = bus.rsp_data;
        a.rwen = bus.rsp_wen; a.pv = bus.port_valid; a.pt = bus.port_req_tag_in;
        a.pa = bus.port_addr; a.pd = bus.port_data_in; a.pw = bus.port_wen;
        a.err = bus.protocol_error;
        return a;
    endfunction

    // Fields without a defined value (stale port payload, idle response data) are masked.
    task automatic check_vec(input vec_t v);
        exp_t a;
        bit   ok;
        a  = sample();
        ok = (a.rdy == v.e.rdy) && (a.rv == v.e.rv) && (a.pv == v.e.pv) && (a.err == v.e.err);
        if (v.full || v.e.rv) ok = ok && (a.rwen == v.e.rwen);
        if (v.full || (v.e.rv && !v.e.rwen)) ok = ok && (a.rdata == v.e.rdata);
        if (v.full || v.e.pv)
            ok = ok && (a.pt == v.e.pt) && (a.pa == v.e.pa) && (a.pd == v.e.pd) && (a.pw == v.e.pw);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", v.name, a, v.e);
        end
    endtask

    task automatic check_bit(input string nm, input logic act, input logic req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %b required %b", nm, act, req);
        end
    endtask

    // Issue one read, answer it immediately, and take the response.
    task automatic roundtrip(input logic [11:0] addr, input logic [15:0] data,
                             input logic [1:0] tag);
        int n;
        @(negedge clk);
        drive(vi(0, 1, int'(addr), 0, 0, 0, 0, 0, 0, 0));
        #1;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_bit("rt_ready_wait", n < 20, 1'b1);
        @(negedge clk);
        drive(vi(0, 0, 0, 0, 0, 0, 0, 1, int'(tag), int'(data)));
        #1;
        check_bit("rt_port_issue", bus.port_valid && bus.port_req_tag_in == tag &&
                  bus.port_addr == addr && !bus.port_wen, 1'b1);
        @(negedge clk);
        drive(vi(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        #1;
        check_bit("rt_rsp", bus.rsp_valid && bus.rsp_data == data && !bus.rsp_wen, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        // single read
        add("rst_state",   1, vi(0,0,0,0,0,0,0,0,0,0),               ve(1,0,0,0,0,0,0,0,0,0));
        add("rd_issue",    1, vi(0,1,'h123,0,0,0,0,0,0,0),           ve(1,0,0,0,0,0,0,0,0,0));
        add("rd_port",     0, vi(0,0,0,0,0,0,0,0,0,0),               ve(1,0,0,0,1,0,'h123,0,0,0));
        add("rd_rsp_in",   0, vi(0,0,0,0,0,0,0,1,0,'hBEEF),          ve(1,0,0,0,0,0,0,0,0,0));
        add("rd_rsp_out",  0, vi(0,0,0,0,0,1,0,0,0,0),               ve(1,1,'hBEEF,0,0,0,0,0,0,0));
        add("rd_done",     0, vi(0,0,0,0,0,0,0,0,0,0),               ve(1,0,0,0,0,0,0,0,0,0));
        // write then freeze for three cycles with another request pending
        add("wr_issue",    0, vi(0,1,'h0A5,'h1234,1,0,0,0,0,0),      ve(1,0,0,0,0,0,0,0,0,0));
        add("frz_1",       0, vi(0,1,'h0FF,'hAAAA,0,0,1,0,0,0),      ve(0,0,0,0,1,1,'h0A5,'h1234,1,0));
        add("frz_2",       0, vi(0,1,'h0FF,'hAAAA,0,0,1,0,0,0),      ve(0,0,0,0,1,1,'h0A5,'h1234,1,0));
        add("frz_3",       0, vi(0,1,'h0FF,'hAAAA,0,0,1,0,0,0),      ve(0,0,0,0,1,1,'h0A5,'h1234,1,0));
        add("frz_release", 0, vi(0,1,'h0FF,'hAAAA,0,0,0,0,0,0),      ve(1,0,0,0,1,1,'h0A5,'h1234,1,0));
        add("frz_next",    0, vi(0,0,0,0,0,0,0,1,1,0),               ve(1,0,0,0,1,2,'h0FF,'hAAAA,0,0));
        add("wr_rsp_out",  0, vi(0,0,0,0,0,1,0,0,0,0),               ve(1,1,0,1,0,0,0,0,0,0));
        add("rd2_rsp_in",  0, vi(0,0,0,0,0,1,0,1,2,'h5555),          ve(1,0,0,0,0,0,0,0,0,0));
        add("rd2_rsp_out", 0, vi(0,0,0,0,0,1,0,0,0,0),               ve(1,1,'h5555,0,0,0,0,0,0,0));
        add("realign_rst", 0, vi(1,0,0,0,0,0,0,0,0,0),               ve(1,0,0,0,0,0,0,0,0,0));
        // four reads, responses in tag order 2,0,3,1
        add("ooo_i0",      1, vi(0,1,'h100,0,0,0,0,0,0,0),           ve(1,0,0,0,0,0,0,0,0,0));
        add("ooo_i1",      0, vi(0,1,'h101,0,0,0,0,0,0,0),           ve(1,0,0,0,1,0,'h100,0,0,0));
        add("ooo_i2",      0, vi(0,1,'h102,0,0,0,0,0,0,0),           ve(1,0,0,0,1,1,'h101,0,0,0));
        add("ooo_i3",      0, vi(0,1,'h103,0,0,0,0,0,0,0),           ve(1,0,0,0,1,2,'h102,0,0,0));
        add("ooo_full_t2", 0, vi(0,1,'h104,0,0,0,0,1,2,'hC002),      ve(0,0,0,0,1,3,'h103,0,0,0));
        add("ooo_t0",      0, vi(0,1,'h104,0,0,0,0,1,0,'hC000),      ve(0,0,0,0,0,0,0,0,0,0));
        add("ooo_t3_hold", 0, vi(0,1,'h104,0,0,0,0,1,3,'hC003),      ve(0,1,'hC000,0,0,0,0,0,0,0));
        add("ooo_t1_ret0", 0, vi(0,1,'h104,0,0,1,0,1,1,'hC001),      ve(0,1,'hC000,0,0,0,0,0,0,0));
        add("full_reissue",0, vi(0,1,'h104,0,0,1,0,0,0,0),           ve(1,1,'hC001,0,0,0,0,0,0,0));
        add("ooo_ret2",    0, vi(0,0,0,0,0,1,0,0,0,0),               ve(1,1,'hC002,0,1,0,'h104,0,0,0));
        add("ooo_ret3",    0, vi(0,0,0,0,0,1,0,0,0,0),               ve(1,1,'hC003,0,0,0,0,0,0,0));
        add("ooo_empty",   0, vi(0,0,0,0,0,1,0,0,0,0),               ve(1,0,0,0,0,0,0,0,0,0));
        // response for unallocated tag 1 while tag 0 is outstanding
        add("perr_hit",    0, vi(0,0,0,0,0,0,0,1,1,'hDEAD),          ve(1,0,0,0,0,0,0,0,0,0));
        add("perr_t0_rsp", 0, vi(0,0,0,0,0,0,0,1,0,'h0042),          ve(1,0,0,0,0,0,0,0,0,1));
        add("perr_t0_out", 0, vi(0,0,0,0,0,1,0,0,0,0),               ve(1,1,'h0042,0,0,0,0,0,0,1));
        add("perr_sticky", 0, vi(0,0,0,0,0,0,0,0,0,0),               ve(1,0,0,0,0,0,0,0,0,1));
        // three outstanding, then reset
        add("mid_i1",      0, vi(0,1,'h200,0,0,0,0,0,0,0),           ve(1,0,0,0,0,0,0,0,0,1));
        add("mid_i2",      0, vi(0,1,'h201,0,0,0,0,0,0,0),           ve(1,0,0,0,1,1,'h200,0,0,1));
        add("mid_i3",      0, vi(0,1,'h202,0,0,0,0,0,0,0),           ve(1,0,0,0,1,2,'h201,0,0,1));
        add("mid_reset",   0, vi(1,0,0,0,0,0,0,0,0,0),               ve(1,0,0,0,1,3,'h202,0,0,1));
        add("post_reset",  1, vi(0,0,0,0,0,0,0,0,0,0),               ve(1,0,0,0,0,0,0,0,0,0));
        add("late_rsp",    1, vi(0,0,0,0,0,0,0,1,2,'h1111),          ve(1,0,0,0,0,0,0,0,0,0));
        add("late_err",    0, vi(0,0,0,0,0,0,0,0,0,0),               ve(1,0,0,0,0,0,0,0,0,1));
        // freeze with no port request pending does not block the client
        add("frz_idle",    0, vi(0,1,'h300,0,0,0,1,0,0,0),           ve(1,0,0,0,0,0,0,0,0,1));
        add("frz_busy",    0, vi(0,0,0,0,0,0,1,0,0,0),               ve(0,0,0,0,1,0,'h300,0,0,1));
        add("frz_off",     0, vi(0,0,0,0,0,0,0,0,0,0),               ve(1,0,0,0,1,0,'h300,0,0,1));
        add("t300_rsp_in", 0, vi(0,0,0,0,0,0,0,1,0,'h3030),          ve(1,0,0,0,0,0,0,0,0,1));
        add("t300_rsp_out",0, vi(0,0,0,0,0,1,0,0,0,0),               ve(1,1,'h3030,0,0,0,0,0,0,1));

        drive(vi(1,0,0,0,0,0,0,0,0,0));
        repeat (2) @(negedge clk);
        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clk);
            drive(tbl[k].i);
            #1;
            check_vec(tbl[k]);
        end

        // issue pointer is at 1 here; walk it across the wrap
        for (int k = 0; k < 6; k++)
            roundtrip(12'h400 + 12'(k), 16'h7000 + 16'(k), 2'(k + 1));

        @(negedge clk);
        drive(vi(0,0,0,0,0,0,0,0,0,0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
